// File: rtl/ddr_arb_pkg.sv
// Shared types and defaults for the two-master DDR bus arbiter.
package ddr_arb_pkg;

  localparam int ARB_ADDR_W = 25;
  localparam int ARB_LEN_W  = 4;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/ddr_bus_arbiter.sv
// Round-robin arbiter merging the CPU bus and a locked read-burst DMA port
// onto the single-outstanding ddr_valid/ddr_ready bridge interface.
module ddr_bus_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LEN_W  = ARB_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ack,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [LEN_W-1:0]  m1_len,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_last,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic [31:0]       ddr_wdata,
  output logic [3:0]        ddr_wstrb,
  output logic              ddr_valid,
  input  logic              ddr_ready,
  input  logic [31:0]       ddr_rdata
);

  arb_state_t        state_r, state_s;
  logic              owner_r, owner_s;
  logic              last_grant_r, last_grant_s;
  logic [LEN_W-1:0]  cnt_r, cnt_s;
  logic [ADDR_W-1:0] addr_s;
  logic [31:0]       wdata_s;
  logic [3:0]        wstrb_s;
  logic              valid_s;
  logic              m0_ready_s;
  logic [31:0]       m0_rdata_s;
  logic              m1_rvalid_s;
  logic              m1_last_s;
  logic [31:0]       m1_rdata_s;
  logic              grant_s;
  logic              pick_dma_s;
  logic              burst_more_s;
  logic              unused_s;

  // On a tie the master that did not win last time takes the bus.
  assign grant_s      = (state_r == IDLE) && (m0_valid || m1_valid);
  assign pick_dma_s   = m1_valid && (!m0_valid || (last_grant_r == OWN_CPU));
  assign burst_more_s = (owner_r == OWN_DMA) && (cnt_r != {LEN_W{1'b0}});
  assign m1_ack       = grant_s && pick_dma_s;
  assign unused_s     = ^m1_addr[1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (m0_valid || m1_valid) state_s = ISSUE;
        else                      state_s = IDLE;
      end
      ISSUE: begin
        if (ddr_ready) state_s = RESP;
        else           state_s = ISSUE;
      end
      RESP: begin
        if (burst_more_s) state_s = ISSUE;
        else              state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values for the registered bridge request, responses and burst counter.
  always_comb begin
    owner_s      = owner_r;
    last_grant_s = last_grant_r;
    cnt_s        = cnt_r;
    addr_s       = ddr_addr;
    wdata_s      = ddr_wdata;
    wstrb_s      = ddr_wstrb;
    valid_s      = ddr_valid;
    m0_ready_s   = 1'b0;
    m0_rdata_s   = m0_rdata;
    m1_rvalid_s  = 1'b0;
    m1_last_s    = 1'b0;
    m1_rdata_s   = m1_rdata;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          owner_s      = pick_dma_s ? OWN_DMA : OWN_CPU;
          last_grant_s = pick_dma_s ? OWN_DMA : OWN_CPU;
          valid_s      = 1'b1;
          if (pick_dma_s) begin
            addr_s  = {m1_addr[ADDR_W-1:2], 2'b00};
            wdata_s = 32'h0000_0000;
            wstrb_s = 4'b0000;
            cnt_s   = m1_len;
          end else begin
            addr_s  = m0_addr;
            wdata_s = m0_wdata;
            wstrb_s = m0_wstrb;
          end
        end else begin
          valid_s = 1'b0;
        end
      end
      ISSUE: begin
        if (ddr_ready) begin
          valid_s = 1'b0;
          if (owner_r == OWN_DMA) begin
            m1_rvalid_s = 1'b1;
            m1_rdata_s  = ddr_rdata;
            m1_last_s   = (cnt_r == {LEN_W{1'b0}});
          end else begin
            m0_ready_s = 1'b1;
            m0_rdata_s = ddr_rdata;
          end
        end else begin
          valid_s = 1'b1;
        end
      end
      RESP: begin
        if (burst_more_s) begin
          cnt_s   = cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
          addr_s  = ddr_addr + ADDR_W'(WORD_BYTES);
          valid_s = 1'b1;
        end else begin
          valid_s = 1'b0;
        end
      end
      default: begin
        valid_s = 1'b0;
      end
    endcase
  end

  // Registered outputs and arbitration bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r      <= OWN_CPU;
      last_grant_r <= OWN_DMA;
      cnt_r        <= {LEN_W{1'b0}};
      ddr_addr     <= {ADDR_W{1'b0}};
      ddr_wdata    <= 32'h0000_0000;
      ddr_wstrb    <= 4'b0000;
      ddr_valid    <= 1'b0;
      m0_ready     <= 1'b0;
      m0_rdata     <= 32'h0000_0000;
      m1_rvalid    <= 1'b0;
      m1_last      <= 1'b0;
      m1_rdata     <= 32'h0000_0000;
    end else begin
      owner_r      <= owner_s;
      last_grant_r <= last_grant_s;
      cnt_r        <= cnt_s;
      ddr_addr     <= addr_s;
      ddr_wdata    <= wdata_s;
      ddr_wstrb    <= wstrb_s;
      ddr_valid    <= valid_s;
      m0_ready     <= m0_ready_s;
      m0_rdata     <= m0_rdata_s;
      m1_rvalid    <= m1_rvalid_s;
      m1_last      <= m1_last_s;
      m1_rdata     <= m1_rdata_s;
    end
  end

endmodule

// File: tb/tb_ddr_bus_arbiter.sv
// Self-checking bench: directed table, mid-burst and reset sequences, then
// randomized episodes against a transaction-level arbitration model.
module tb_ddr_bus_arbiter;

  localparam int AW = 25;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_valid, m0_ready;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wdata;
  logic [3:0]    m0_wstrb;
  logic [31:0]   m0_rdata;
  logic          m1_valid, m1_ack;
  logic [AW-1:0] m1_addr;
  logic [LW-1:0] m1_len;
  logic          m1_rvalid, m1_last;
  logic [31:0]   m1_rdata;
  logic [AW-1:0] ddr_addr;
  logic [31:0]   ddr_wdata;
  logic [3:0]    ddr_wstrb;
  logic          ddr_valid, ddr_ready;
  logic [31:0]   ddr_rdata;

  ddr_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ack(m1_ack), .m1_addr(m1_addr), .m1_len(m1_len),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_last(m1_last),
    .ddr_addr(ddr_addr), .ddr_wdata(ddr_wdata), .ddr_wstrb(ddr_wstrb),
    .ddr_valid(ddr_valid), .ddr_ready(ddr_ready), .ddr_rdata(ddr_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;
  int last_g = 1;  // model: who was granted most recently (0 = CPU, 1 = DMA)

  typedef struct {
    bit          r0;
    bit          r1;
    logic [31:0] a0;
    logic [31:0] wd0;
    logic [3:0]  ws0;
    logic [31:0] a1;
    int          len;
    int          k;
    logic [31:0] rd;
    int          first;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_addr(input logic [31:0] base, input int w);
    return (((base >> 2) << 2) + 32'(4 * w)) % 32'h0200_0000;
  endfunction

  // Entered in the grant cycle; leaves in the following IDLE cycle with m0_valid dropped.
  task automatic serve_m0(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input int k, input logic [31:0] rd);
    int t0;
    int kk;
    t0 = cyc;
    kk = (k < 0) ? int'($urandom_range(0, 3)) : k;
    tick();
    chk("m0_req_valid", 32'(ddr_valid), 32'd1);
    chk("m0_req_addr", 32'(ddr_addr), a);
    chk("m0_req_wdata", ddr_wdata, wd);
    chk("m0_req_wstrb", 32'(ddr_wstrb), 32'(ws));
    repeat (kk) tick();
    chk("m0_hold_valid", 32'(ddr_valid), 32'd1);
    chk("m0_hold_addr", 32'(ddr_addr), a);
    chk("m0_no_early_ready", 32'(m0_ready), 32'd0);
    ddr_ready = 1'b1;
    ddr_rdata = rd;
    tick();
    ddr_ready = 1'b0;
    ddr_rdata = $urandom;
    chk("m0_ready", 32'(m0_ready), 32'd1);
    chk("m0_rdata", m0_rdata, rd);
    chk("m0_latency", 32'(cyc - t0), 32'(2 + kk));
    chk("m0_valid_cleared", 32'(ddr_valid), 32'd0);
    chk("m0_no_dma_pulse", 32'(m1_rvalid), 32'd0);
    tick();
    m0_valid = 1'b0;
    chk("m0_ready_one_cycle", 32'(m0_ready), 32'd0);
    last_g = 0;
  endtask

  // Entered in the grant cycle; optionally re-raises both masters during word raise_w.
  task automatic serve_m1(input logic [31:0] a, input int len, input int k, input int raise_w);
    int t0;
    int acc;
    int kk;
    logic [31:0] rd;
    t0  = cyc;
    acc = 0;
    tick();
    m1_valid = 1'b0;
    for (int w = 0; w <= len; w++) begin
      kk = (k < 0) ? int'($urandom_range(0, 3)) : k;
      chk("m1_req_valid", 32'(ddr_valid), 32'd1);
      chk("m1_req_addr", 32'(ddr_addr), word_addr(a, w));
      chk("m1_req_wstrb", 32'(ddr_wstrb), 32'd0);
      chk("m1_req_wdata", ddr_wdata, 32'd0);
      if (w == raise_w) begin
        m0_valid = 1'b1;
        m1_valid = 1'b1;
      end
      repeat (kk) tick();
      acc += kk;
      rd = $urandom;
      ddr_ready = 1'b1;
      ddr_rdata = rd;
      tick();
      ddr_ready = 1'b0;
      chk("m1_rvalid", 32'(m1_rvalid), 32'd1);
      chk("m1_rdata", m1_rdata, rd);
      chk("m1_last", 32'(m1_last), (w == len) ? 32'd1 : 32'd0);
      chk("m1_word_time", 32'(cyc - t0), 32'(2 + acc + 2 * w));
      chk("m1_no_cpu_pulse", 32'(m0_ready), 32'd0);
      tick();
    end
    chk("m1_rvalid_end", 32'(m1_rvalid), 32'd0);
    chk("m1_last_end", 32'(m1_last), 32'd0);
    last_g = 1;
  endtask

  // Both masters' requests applied together in IDLE; the loser is served afterwards.
  task automatic episode(input bit r0, input bit r1, input logic [31:0] a0, input logic [31:0] wd0,
                         input logic [3:0] ws0, input logic [31:0] a1, input int len, input int k,
                         input logic [31:0] rd, input int first);
    m0_addr  = a0[AW-1:0];
    m0_wdata = wd0;
    m0_wstrb = ws0;
    m0_valid = r0;
    m1_addr  = a1[AW-1:0];
    m1_len   = LW'(len);
    m1_valid = r1;
    #1;
    chk("idle_no_request", 32'(ddr_valid), 32'd0);
    chk("grant_ack", 32'(m1_ack), (first == 1) ? 32'd1 : 32'd0);
    if (first == 0) begin
      serve_m0(a0, wd0, ws0, k, rd);
      if (r1) begin
        #1;
        chk("loser_dma_ack", 32'(m1_ack), 32'd1);
        serve_m1(a1, len, k, -1);
      end
    end else begin
      serve_m1(a1, len, k, -1);
      if (r0) begin
        #1;
        chk("loser_cpu_no_ack", 32'(m1_ack), 32'd0);
        serve_m0(a0, wd0, ws0, k, rd);
      end
    end
  endtask

  initial begin
    int p;
    int first;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
    m1_valid = 1'b0; m1_addr = '0; m1_len = '0;
    ddr_ready = 1'b0; ddr_rdata = 32'd0;

    vt[0] = '{1'b1, 1'b0, 32'h0000100, 32'h0, 4'b0000, 32'h0, 0, 3, 32'hDEADBEEF, 0};
    vt[1] = '{1'b1, 1'b0, 32'h0000200, 32'h12345678, 4'b0011, 32'h0, 0, 1, 32'h0BAD0BAD, 0};
    vt[2] = '{1'b0, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h1FFFFF9, 2, 0, 32'h0, 1};
    vt[3] = '{1'b1, 1'b1, 32'h0000040, 32'hAAAA5555, 4'b1111, 32'h0000800, 1, 2, 32'h11112222, 0};
    vt[4] = '{1'b1, 1'b0, 32'h0000044, 32'h0, 4'b0000, 32'h0, 0, 0, 32'h33334444, 0};
    vt[5] = '{1'b1, 1'b1, 32'h0000048, 32'h0, 4'b0000, 32'h0001000, 0, 1, 32'h55556666, 1};
    vt[6] = '{1'b1, 1'b1, 32'h000004C, 32'h0, 4'b0000, 32'h0001004, 1, 0, 32'h77778888, 1};

    tick();
    tick();
    chk("rst_ddr_valid", 32'(ddr_valid), 32'd0);
    chk("rst_ddr_addr", 32'(ddr_addr), 32'd0);
    chk("rst_m0_ready", 32'(m0_ready), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("rst_m1_last", 32'(m1_last), 32'd0);
    chk("rst_m1_ack", 32'(m1_ack), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++)
      episode(vt[i].r0, vt[i].r1, vt[i].a0, vt[i].wd0, vt[i].ws0, vt[i].a1,
              vt[i].len, vt[i].k, vt[i].rd, vt[i].first);

    // CPU raised mid-burst, DMA re-raised too: CPU goes next, then DMA.
    m0_addr = 25'h0000500; m0_wdata = 32'd0; m0_wstrb = 4'd0;
    m1_addr = 25'h0000300; m1_len = 4'd3; m1_valid = 1'b1;
    #1;
    chk("mid_first_ack", 32'(m1_ack), 32'd1);
    serve_m1(32'h0000300, 3, 1, 1);
    #1;
    chk("mid_cpu_wins", 32'(m1_ack), 32'd0);
    serve_m0(32'h0000500, 32'd0, 4'd0, 1, 32'hCAFEF00D);
    #1;
    chk("mid_dma_after", 32'(m1_ack), 32'd1);
    serve_m1(32'h0000300, 3, 0, -1);

    // Reset while a CPU request is outstanding.
    m0_addr = 25'h0000600; m0_valid = 1'b1;
    tick();
    chk("rst_mid_valid_before", 32'(ddr_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ddr_valid", 32'(ddr_valid), 32'd0);
    chk("rst_mid_m0_ready", 32'(m0_ready), 32'd0);
    chk("rst_mid_m1_rvalid", 32'(m1_rvalid), 32'd0);
    m0_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    last_g = 1;
    tick();
    episode(1'b1, 1'b0, 32'h0000700, 32'h0, 4'b0000, 32'h0, 0, 2, 32'h600DF00D, 0);

    // Randomized episodes; the model picks the first winner from the round-robin rule.
    for (int i = 0; i < 30; i++) begin
      p = int'($urandom_range(1, 3));
      if (p == 3) first = (last_g == 1) ? 0 : 1;
      else        first = (p == 2) ? 1 : 0;
      episode(p[0], p[1], $urandom & 32'h01FF_FFFF, $urandom, 4'($urandom),
              $urandom & 32'h01FF_FFFF, int'($urandom_range(0, 3)), -1, $urandom, first);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
